// File: rtl/citadel_cmd_bridge.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | citadel_cmd_bridge                                                          |
// | CSR-window bridge between the debug bus and the citadel_fpu command ports.  |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+

package citadel_fpu_pkg;
    typedef struct packed {
        logic        exec;
        logic        rf_we;
        logic [4:0]  rf_addr;
        logic [31:0] rf_wdata;
        logic [2:0]  fu_id;
        logic [31:0] fu_imm_opcode;
        logic [4:0]  fu_rs0;
        logic [4:0]  fu_rs1;
        logic [4:0]  fu_rs2;
        logic [4:0]  fu_rd;
    } citadel_fpu_cmd_req_struct;
endpackage

module citadel_cmd_bridge #(
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
    parameter int          CMD_DEPTH  = 4,
    parameter int          RESP_DEPTH = 4
) (
    input  logic                                       clk_i,
    input  logic                                       rst_i,
    input  logic                                       bus_req_i,
    input  logic                                       bus_we_i,
    input  logic [31:0]                                bus_addr_bi,
    input  logic [3:0]                                 bus_be_bi,
    input  logic [31:0]                                bus_wdata_bi,
    output logic                                       bus_ack_o,
    output logic                                       bus_resp_o,
    output logic [31:0]                                bus_rdata_bo,
    output logic                                       cmd_req_genfifo_req_o,
    output citadel_fpu_pkg::citadel_fpu_cmd_req_struct cmd_req_genfifo_wdata_bo,
    input  logic                                       cmd_req_genfifo_ack_i,
    input  logic                                       cmd_resp_genfifo_req_i,
    input  logic [31:0]                                cmd_resp_genfifo_rdata_bi,
    output logic                                       cmd_resp_genfifo_ack_o
);
    localparam int C_CAW = $clog2(CMD_DEPTH);
    localparam int C_RAW = $clog2(RESP_DEPTH);
    localparam logic [C_CAW:0]   C_CMD_FULL  = (C_CAW+1)'(CMD_DEPTH);
    localparam logic [C_RAW:0]   C_RESP_FULL = (C_RAW+1)'(RESP_DEPTH);
    localparam logic [C_CAW-1:0] C_CPTR_ONE  = 1;
    localparam logic [C_RAW-1:0] C_RPTR_ONE  = 1;
    localparam logic [C_CAW:0]   C_CCNT_ONE  = 1;
    localparam logic [C_RAW:0]   C_RCNT_ONE  = 1;

    localparam logic [7:0] C_OFF_CTRL   = 8'h00;
    localparam logic [7:0] C_OFF_EXEC   = 8'h04;
    localparam logic [7:0] C_OFF_RF_WE  = 8'h08;
    localparam logic [7:0] C_OFF_RF_AD  = 8'h0C;
    localparam logic [7:0] C_OFF_RF_WD  = 8'h10;
    localparam logic [7:0] C_OFF_FU_ID  = 8'h14;
    localparam logic [7:0] C_OFF_FU_IMM = 8'h18;
    localparam logic [7:0] C_OFF_RS0    = 8'h1C;
    localparam logic [7:0] C_OFF_RS1    = 8'h20;
    localparam logic [7:0] C_OFF_RS2    = 8'h24;
    localparam logic [7:0] C_OFF_RD     = 8'h28;
    localparam logic [7:0] C_OFF_STATUS = 8'h2C;
    localparam logic [7:0] C_OFF_RDATA  = 8'h40;

    logic [31:0] w_off;
    logic [7:0]  w_sel;
    logic        w_in_window, w_wr, w_rd, w_unused;
    logic        w_cmd_push, w_cmd_full, w_cmd_push_ok, w_cmd_pop;
    logic        w_flush, w_resp_full, w_resp_empty, w_resp_push_ok, w_resp_pop;
    logic        w_rdata_rd, w_status_wr;
    logic [31:0] w_rd_val, w_status;

    citadel_fpu_pkg::citadel_fpu_cmd_req_struct stage_q, stage_d;
    citadel_fpu_pkg::citadel_fpu_cmd_req_struct cmd_mem_q [CMD_DEPTH];
    logic [31:0]      resp_mem_q [RESP_DEPTH];
    logic [C_CAW-1:0] cmd_wptr_q, cmd_wptr_d, cmd_rptr_q, cmd_rptr_d;
    logic [C_CAW:0]   cmd_cnt_q, cmd_cnt_d;
    logic [C_RAW-1:0] resp_wptr_q, resp_wptr_d, resp_rptr_q, resp_rptr_d;
    logic [C_RAW:0]   resp_cnt_q, resp_cnt_d;
    logic             cmd_ovf_q, cmd_ovf_d, resp_ovf_q, resp_ovf_d, resp_udf_q, resp_udf_d;
    logic             bus_resp_q;
    logic [31:0]      bus_rdata_q;

    // Wrapping subtraction: in-window exactly when the offset fits in 8 bits.
    assign w_off       = bus_addr_bi - BASE_ADDR;
    assign w_sel       = w_off[7:0];
    assign w_in_window = (w_off[31:8] == 24'h0);
    assign bus_ack_o   = bus_req_i & w_in_window;
    assign w_wr        = bus_ack_o & bus_we_i;
    assign w_rd        = bus_ack_o & ~bus_we_i;
    assign w_unused    = &{1'b0, bus_be_bi};

    assign w_cmd_full    = (cmd_cnt_q == C_CMD_FULL);
    assign w_cmd_push    = w_wr & (w_sel == C_OFF_CTRL) & bus_wdata_bi[0];
    assign w_cmd_push_ok = w_cmd_push & ~w_cmd_full;
    assign w_cmd_pop     = cmd_req_genfifo_req_o & cmd_req_genfifo_ack_i;

    assign w_flush        = w_wr & (w_sel == C_OFF_CTRL) & bus_wdata_bi[1];
    assign w_resp_full    = (resp_cnt_q == C_RESP_FULL);
    assign w_resp_empty   = (resp_cnt_q == '0);
    assign w_rdata_rd     = w_rd & (w_sel == C_OFF_RDATA);
    assign w_status_wr    = w_wr & (w_sel == C_OFF_STATUS);
    assign w_resp_push_ok = cmd_resp_genfifo_req_i & ~w_resp_full & ~w_flush;
    assign w_resp_pop     = w_rdata_rd & ~w_resp_empty & ~w_flush;

    assign cmd_req_genfifo_req_o    = (cmd_cnt_q != '0);
    assign cmd_req_genfifo_wdata_bo = cmd_mem_q[cmd_rptr_q];
    assign cmd_resp_genfifo_ack_o   = 1'b1;
    assign bus_resp_o               = bus_resp_q;
    assign bus_rdata_bo             = bus_rdata_q;

    assign w_status = {11'h0, resp_udf_q, resp_ovf_q, cmd_ovf_q, w_resp_empty, w_cmd_full,
                       8'(resp_cnt_q), 8'(cmd_cnt_q)};

    always_comb begin
        stage_d = stage_q;
        if (w_wr) begin
            case (w_sel)
                C_OFF_EXEC:   stage_d.exec          = bus_wdata_bi[0];
                C_OFF_RF_WE:  stage_d.rf_we         = bus_wdata_bi[0];
                C_OFF_RF_AD:  stage_d.rf_addr       = bus_wdata_bi[4:0];
                C_OFF_RF_WD:  stage_d.rf_wdata      = bus_wdata_bi;
                C_OFF_FU_ID:  stage_d.fu_id         = bus_wdata_bi[2:0];
                C_OFF_FU_IMM: stage_d.fu_imm_opcode = bus_wdata_bi;
                C_OFF_RS0:    stage_d.fu_rs0        = bus_wdata_bi[4:0];
                C_OFF_RS1:    stage_d.fu_rs1        = bus_wdata_bi[4:0];
                C_OFF_RS2:    stage_d.fu_rs2        = bus_wdata_bi[4:0];
                C_OFF_RD:     stage_d.fu_rd         = bus_wdata_bi[4:0];
                default:      stage_d               = stage_q;
            endcase
        end
    end

    always_comb begin
        w_rd_val = 32'h0;
        case (w_sel)
            C_OFF_EXEC:   w_rd_val = 32'(stage_q.exec);
            C_OFF_RF_WE:  w_rd_val = 32'(stage_q.rf_we);
            C_OFF_RF_AD:  w_rd_val = 32'(stage_q.rf_addr);
            C_OFF_RF_WD:  w_rd_val = stage_q.rf_wdata;
            C_OFF_FU_ID:  w_rd_val = 32'(stage_q.fu_id);
            C_OFF_FU_IMM: w_rd_val = stage_q.fu_imm_opcode;
            C_OFF_RS0:    w_rd_val = 32'(stage_q.fu_rs0);
            C_OFF_RS1:    w_rd_val = 32'(stage_q.fu_rs1);
            C_OFF_RS2:    w_rd_val = 32'(stage_q.fu_rs2);
            C_OFF_RD:     w_rd_val = 32'(stage_q.fu_rd);
            C_OFF_STATUS: w_rd_val = w_status;
            C_OFF_RDATA:  w_rd_val = w_resp_empty ? 32'h0 : resp_mem_q[resp_rptr_q];
            default:      w_rd_val = 32'h0;
        endcase
    end

    always_comb begin
        cmd_wptr_d = cmd_wptr_q;
        cmd_rptr_d = cmd_rptr_q;
        cmd_cnt_d  = cmd_cnt_q;
        if (w_cmd_push_ok) cmd_wptr_d = cmd_wptr_q + C_CPTR_ONE;
        if (w_cmd_pop)     cmd_rptr_d = cmd_rptr_q + C_CPTR_ONE;
        case ({w_cmd_push_ok, w_cmd_pop})
            2'b10:   cmd_cnt_d = cmd_cnt_q + C_CCNT_ONE;
            2'b01:   cmd_cnt_d = cmd_cnt_q - C_CCNT_ONE;
            default: cmd_cnt_d = cmd_cnt_q;
        endcase
    end

    always_comb begin
        resp_wptr_d = resp_wptr_q;
        resp_rptr_d = resp_rptr_q;
        resp_cnt_d  = resp_cnt_q;
        if (w_flush) begin
            resp_wptr_d = '0;
            resp_rptr_d = '0;
            resp_cnt_d  = '0;
        end else begin
            if (w_resp_push_ok) resp_wptr_d = resp_wptr_q + C_RPTR_ONE;
            if (w_resp_pop)     resp_rptr_d = resp_rptr_q + C_RPTR_ONE;
            case ({w_resp_push_ok, w_resp_pop})
                2'b10:   resp_cnt_d = resp_cnt_q + C_RCNT_ONE;
                2'b01:   resp_cnt_d = resp_cnt_q - C_RCNT_ONE;
                default: resp_cnt_d = resp_cnt_q;
            endcase
        end
    end

    // A new overflow/underflow event wins over a same-cycle write-1-to-clear.
    always_comb begin
        cmd_ovf_d  = cmd_ovf_q;
        resp_ovf_d = resp_ovf_q;
        resp_udf_d = resp_udf_q;
        if (w_status_wr && bus_wdata_bi[18]) cmd_ovf_d  = 1'b0;
        if (w_status_wr && bus_wdata_bi[19]) resp_ovf_d = 1'b0;
        if (w_status_wr && bus_wdata_bi[20]) resp_udf_d = 1'b0;
        if (w_cmd_push && w_cmd_full) cmd_ovf_d = 1'b1;
        if (cmd_resp_genfifo_req_i && w_resp_full && !w_flush) resp_ovf_d = 1'b1;
        if (w_rdata_rd && w_resp_empty) resp_udf_d = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (w_cmd_push_ok)  cmd_mem_q[cmd_wptr_q]   <= stage_q;
        if (w_resp_push_ok) resp_mem_q[resp_wptr_q] <= cmd_resp_genfifo_rdata_bi;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stage_q     <= '0;
            cmd_wptr_q  <= '0;
            cmd_rptr_q  <= '0;
            cmd_cnt_q   <= '0;
            resp_wptr_q <= '0;
            resp_rptr_q <= '0;
            resp_cnt_q  <= '0;
            cmd_ovf_q   <= 1'b0;
            resp_ovf_q  <= 1'b0;
            resp_udf_q  <= 1'b0;
            bus_resp_q  <= 1'b0;
            bus_rdata_q <= 32'h0;
        end else begin
            stage_q     <= stage_d;
            cmd_wptr_q  <= cmd_wptr_d;
            cmd_rptr_q  <= cmd_rptr_d;
            cmd_cnt_q   <= cmd_cnt_d;
            resp_wptr_q <= resp_wptr_d;
            resp_rptr_q <= resp_rptr_d;
            resp_cnt_q  <= resp_cnt_d;
            cmd_ovf_q   <= cmd_ovf_d;
            resp_ovf_q  <= resp_ovf_d;
            resp_udf_q  <= resp_udf_d;
            bus_resp_q  <= w_rd;
            bus_rdata_q <= w_rd ? w_rd_val : 32'h0;
        end
    end
endmodule
`default_nettype wire

// File: doc/citadel_cmd_bridge.md
# citadel_cmd_bridge

Bus-side command/response bridge between the UDM debug bus master and the `citadel_fpu` core. It decodes a CSR window, stages the command fields, and queues complete commands into the core's `cmd_req` genfifo port. It also buffers the core's 32-bit `cmd_resp` words in a FIFO that the host drains by polling. It replaces ad-hoc single-word CSR glue in the top level with backpressure-safe queuing and sticky error status.

## Interface
- `BASE_ADDR`, default 32'h10000000: base of the 256-byte CSR window.
- `CMD_DEPTH`, default 4: command queue entries; must be a power of 2, between 2 and 64.
- `RESP_DEPTH`, default 4: response queue entries; must be a power of 2, between 2 and 64.
- `clk_i`  in  1: the single clock.
- `rst_i`  in  1: reset, synchronous and active-high.
- `bus_req_i`  in  1: bus request.
- `bus_we_i`  in  1: 1 = write, 0 = read.
- `bus_addr_bi`  in  32: byte address.
- `bus_be_bi`  in  4: byte enables; ignored, all accesses are full 32-bit words.
- `bus_wdata_bi`  in  32: write data.
- `bus_ack_o`  out  1: request accepted.
- `bus_resp_o`  out  1: read data valid.
- `bus_rdata_bo`  out  32: read data.
- `cmd_req_genfifo_req_o`  out  1: command valid toward the core.
- `cmd_req_genfifo_wdata_bo`  out  `citadel_fpu_cmd_req_struct`: command payload.
- `cmd_req_genfifo_ack_i`  in  1: core accepts the command.
- `cmd_resp_genfifo_req_i`  in  1: core response valid.
- `cmd_resp_genfifo_rdata_bi`  in  32: core response word.
- `cmd_resp_genfifo_ack_o`  out  1: constant 1; the core is never stalled.

## Operation
- **Window and acknowledge.** A request is in-window when `BASE_ADDR <= addr < BASE_ADDR+0x100`. `bus_ack_o = bus_req_i & in_window`. Out-of-window requests are neither acked nor responded to.
- **Staging registers.** Offsets 0x04 `exec`, 0x08 `rf_we`, 0x0C `rf_addr`, 0x10 `rf_wdata`, 0x14 `fu_id`, 0x18 `fu_imm_opcode`, 0x1C/0x20/0x24 `fu_rs0/1/2`, 0x28 `fu_rd`.
  - Writes load the field with the low bits of wdata, truncated to the struct field width.
  - Reads return the stored field, zero-extended.
  - Staged values persist after a push, so repeated pushes resend the same command.
- **CTRL (0x00, write).**
  - bit0 = 1 pushes the staged struct into the command queue.
  - bit1 = 1 flushes the response queue.
  - Reads of CTRL return 0.
- **STATUS (0x2C).** Read fields:
  - [7:0] cmd count
  - [15:8] resp count
  - [16] cmd_full
  - [17] resp_empty
  - [18] cmd_ovf (sticky)
  - [19] resp_ovf (sticky)
  - [20] resp_udf (sticky)

  Writing 1 to bit 18, 19 or 20 clears that bit.
- **RDATA (0x40, read).** Returns the resp queue head and pops it. When the queue is empty it returns 32'h0 and sets resp_udf.
- **Unused in-window offsets.** Writes are ignored; reads return 0 with a normal response.
- **Command queue.** Circular buffer with read/write pointers that wrap modulo `CMD_DEPTH`.
  - `cmd_req_genfifo_req_o = (count != 0)`; the payload is the head entry.
  - Pop happens on `req_o & ack_i`.
  - Push when count == `CMD_DEPTH` (sampled before this cycle's pop) is dropped and sets cmd_ovf.
  - Push and pop in the same cycle when not full leaves the count unchanged.
- **Response queue.** Same structure.
  - Push on `cmd_resp_genfifo_req_i`. Push when full (sampled before pop) is dropped and sets resp_ovf.
  - Flush has priority over everything else: count goes to 0, and a same-cycle incoming word and same-cycle pop are discarded without setting any sticky bit.
- **Reset.**
  - All staging registers, pointers, counts and sticky bits go to 0.
  - `cmd_req_genfifo_req_o = 0`, `bus_resp_o = 0`, `bus_rdata_bo = 0`, `cmd_resp_genfifo_ack_o = 1`.
  - Queue contents are don't-care; entries in flight are lost.

## Timing
- **Writes.** Accepted in cycle N; the register update, push and flush take effect at the end of N. For a push in N, `cmd_req_genfifo_req_o` is high at the earliest in N+1.
- **Reads.** Accepted in N; `bus_resp_o` is pulsed for one cycle in N+1 with `bus_rdata_bo` valid. `bus_rdata_bo` returns to 0 when `bus_resp_o` is 0. Back-to-back reads give back-to-back responses.
- **Response visibility.** A response word captured in N is visible in STATUS and RDATA for a request accepted in N+1.
- **STATUS snapshot.** STATUS shows the values registered at the end of the request cycle N, before any same-cycle core traffic is applied.
- **Core handshake.** The command payload is stable while req=1 and ack=0. Throughput is one command per cycle when ack is held high.

## Test plan
- **Reset defaults.** Reset, then read STATUS → 32'h00020000 (resp_empty set, all counts 0).
- **Single command.** Write rf_addr=5, rf_wdata=32'h3F800000, rf_we=1, then CTRL=1, with ack_i held low → req_o=1 in the cycle after the CTRL write, payload rf_addr=5, STATUS cmd count 1. Raise ack → req_o drops next cycle, count 0.
- **Command overflow.** With ack_i=0, write CTRL=1 five times (CMD_DEPTH=4) → cmd_full=1, cmd_ovf=1, count 4. Release ack → exactly 4 commands delivered. Write STATUS=32'h40000 → cmd_ovf=0.
- **Response ordering.** Core pushes 32'hA, 32'hB, 32'hC → three RDATA reads return A, B, C, each one cycle after its request. A fourth read returns 0 and sets resp_udf.
- **Response flush and overflow.** Push 5 words → resp_ovf=1, count 4. Write CTRL=2 in the same cycle as a 6th push → count 0, resp_empty=1, and resp_ovf stays 1 from the earlier overflow (the 6th word is discarded silently, no new sticky event).
- **Window decode.** Read 32'h10000100 → bus_ack_o=0 and no `bus_resp_o`. Read 32'h10000030 → response with 0.
